// File: rtl/inv_sub_word_if.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sub_word_if
//  Description : Word-in / word-out valid-ready bundle for inv_sub_word.
//  Revision    : 1.0  initial release
// ============================================================================
interface inv_sub_word_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        busy;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, busy
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, busy
    );
endinterface
`default_nettype wire

// File: rtl/inv_sub_word.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sub_word
//  Description : Serial AES InvSubWord, one byte at a time via x^254 chain.
//  Revision    : 1.0  initial release
// ============================================================================
module inv_sub_word (
    input  wire logic         clk,
    input  wire logic         rst,
    inv_sub_word_if.slave     bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_MUL     = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;
    localparam logic [3:0] LAST_STEP = 4'd12;
    localparam logic [1:0] LAST_BYTE = 2'd3;
    localparam logic [7:0] AFFINE_C  = 8'h05;
    localparam logic [7:0] POLY_LOW  = 8'h1B;

    logic [1:0]  state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [31:0] res_q, res_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  step_q, step_d;
    logic [7:0]  base_q, base_d;
    logic [7:0]  acc_q, acc_d;

    logic [4:0]  lane_lsb;
    logic [7:0]  sel_byte;
    logic [7:0]  mul_b;
    logic [7:0]  mul_p;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? POLY_LOW : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] y);
        return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ AFFINE_C;
    endfunction

    // Byte index 0 maps to lane [31:24], so the lane offset is 8*(3-idx).
    assign lane_lsb = {~idx_q, 3'b000};
    assign sel_byte = word_q[lane_lsb +: 8];

    // Even steps square the accumulator, odd steps multiply in the base.
    assign mul_b = step_q[0] ? base_q : acc_q;
    assign mul_p = gf_mul(acc_q, mul_b);

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_LOAD) || (state_q == S_MUL);
    assign bus.out_word  = res_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        res_d   = res_q;
        idx_d   = idx_q;
        step_d  = step_q;
        base_d  = base_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_word;
                    idx_d   = 2'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                base_d  = inv_affine(sel_byte);
                acc_d   = inv_affine(sel_byte);
                step_d  = 4'd0;
                state_d = S_MUL;
            end
            S_MUL: begin
                acc_d  = mul_p;
                step_d = step_q + 4'd1;
                if (step_q == LAST_STEP) begin
                    res_d[lane_lsb +: 8] = mul_p;
                    if (idx_q == LAST_BYTE) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            word_q  <= 32'h0;
            res_q   <= 32'h0;
            idx_q   <= 2'd0;
            step_q  <= 4'd0;
            base_q  <= 8'h00;
            acc_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_inv_sub_word.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_sub_word
//  Description : Self-checking bench for inv_sub_word against an S-box model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inv_sub_word;
    localparam int LAT     = 56;
    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inv_sub_word_if bus();
    inv_sub_word dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic int gmul(input int a, input int b);
        int p = 0;
        for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int i = 14; i >= 8; i--) if (((p >> i) & 1) != 0) p = p ^ ('h11B << (i - 8));
        return p;
    endfunction

    function automatic int rotl8(input int b, input int n);
        return ((b << n) | (b >> (8 - n))) & 255;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] w);
        return {isbox[w[31:24]], isbox[w[23:16]], isbox[w[15:8]], isbox[w[7:0]]};
    endfunction

    // Forward S-box from brute-force inverses, then inverted by table swap.
    initial begin
        for (int x = 0; x < 256; x++) begin
            int inv = 0;
            for (int z = 1; z < 256; z++) if (x != 0 && gmul(x, z) == 1) inv = z;
            sbox[8'(x)] = 8'(inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                             ^ rotl8(inv, 4) ^ 'h63);
        end
        for (int x = 0; x < 256; x++) isbox[sbox[8'(x)]] = 8'(x);
    end

    // Timing model: idle, 56 compute edges, then valid until out_ready.
    logic        m_live  = 1'b0;
    logic        m_pend  = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_exp   = 32'h0;
    logic        m_known = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1; m_pend = 1'b0; m_cnt = 0; m_exp = 32'h0; m_known = 1'b1;
        end else if (!m_pend) begin
            if (bus.in_valid) begin
                m_pend = 1'b1; m_cnt = 0; m_known = 1'b0;
                m_exp  = model_word(bus.in_word);
            end
        end else if (m_cnt < LAT) begin
            m_cnt++;
            if (m_cnt == LAT) m_known = 1'b1;
        end else if (bus.out_ready) begin
            m_pend = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready",  32'(bus.in_ready),  32'(!m_pend));
            chk("out_valid", 32'(bus.out_valid), 32'(m_pend && m_cnt == LAT));
            chk("busy",      32'(bus.busy),      32'(m_pend && m_cnt < LAT));
            if (m_known) chk("out_word", bus.out_word, m_exp);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_word = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < TIMEOUT) begin @(negedge clk); n++; end
        if (!bus.in_ready) chk("timeout_in_ready", 32'(bus.in_ready), 32'h1);
    endtask

    // Sends one word and returns the result plus edges from acceptance to out_valid.
    task automatic xfer(input logic [31:0] w, input int rdy_delay,
                        output logic [31:0] got, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_word = w; bus.out_ready = 1'b0;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_word   = $urandom;
        bus.out_ready = (rdy_delay == 0);
        lat = 0;
        while (!bus.out_valid && lat < TIMEOUT) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        if (!bus.out_valid) chk("timeout_out_valid", 32'(bus.out_valid), 32'h1);
        got = bus.out_word;
        if (rdy_delay > 0) begin
            repeat (rdy_delay) @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        int          lat;
        int          n;
        logic        seen;
        logic [7:0]  x0, x1, x2, x3;

        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_word = 32'h0;
        #1;
        chk("model_sbox_00",  32'(sbox[8'h00]),  32'h63);
        chk("model_sbox_53",  32'(sbox[8'h53]),  32'hED);
        chk("model_isbox_16", 32'(isbox[8'h16]), 32'hFF);

        do_reset();
        chk("rst_in_ready",  32'(bus.in_ready),  32'h1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_busy",      32'(bus.busy),      32'h0);
        chk("rst_out_word",  bus.out_word,       32'h0);

        // Latency counted from the accepting edge: the 57th edge including it.
        xfer(32'h637C7716, 0, got, lat);
        chk("vec_637C7716", got, 32'h000102FF);
        chk("lat_637C7716", 32'(lat), 32'(LAT));

        xfer(32'h52ED0016, 0, got, lat);
        chk("vec_52ED0016", got, 32'h485352FF);

        xfer(32'h00000000, 10, got, lat);
        chk("vec_zero_stall", got, 32'h52525252);
        chk("hold_after_done", bus.out_word, 32'h52525252);

        // Reset in the middle of a transaction must discard it silently.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_word = 32'hDEADBEEF; bus.out_ready = 1'b1;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (80) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
        chk("rst_mid_no_valid", 32'(seen), 32'h0);
        xfer(32'h637C7716, 0, got, lat);
        chk("after_rst_vec", got, 32'h000102FF);

        // in_valid held across two words: second accepted right after the handshake.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_word = 32'h637C7716; bus.out_ready = 1'b1;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        bus.in_word = 32'h52ED0016;
        n = 0;
        while (!bus.in_ready && n < TIMEOUT) begin
            if (bus.out_valid) chk("b2b_first", bus.out_word, 32'h000102FF);
            @(posedge clk); n++; @(negedge clk);
        end
        chk("b2b_gap_edges", 32'(n), 32'(LAT + 1));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < TIMEOUT) begin @(negedge clk); n++; end
        chk("b2b_second", bus.out_word, 32'h485352FF);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Every byte value in every lane, as an S-then-InvS round trip.
        for (int v = 0; v < 256; v++) begin
            x0 = 8'(v); x1 = 8'(v) ^ 8'hA5; x2 = 8'(v) + 8'd77; x3 = ~8'(v);
            xfer({sbox[x0], sbox[x1], sbox[x2], sbox[x3]},
                 (v % 16 == 0) ? int'($urandom_range(1, 4)) : 0, got, lat);
            chk("round_trip", got, {x0, x1, x2, x3});
        end

        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer($urandom, int'($urandom_range(0, 4)), got, lat);
            chk("rand_latency", 32'(lat), 32'(LAT));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
